// File: rtl/bank_inrd_sequencer_if.sv
// Request handshake between a mask producer and the bank input-ready sequencer.
// The sequencer side owns req_ready/busy; the producer side owns the mask request.
interface bank_inrd_sequencer_if #(
   parameter int NUM_BANKS = 6
);
   logic                 req_valid;
   logic [NUM_BANKS-1:0] req_mask;
   logic                 req_ready;
   logic                 busy;

   modport master (
      output req_valid,
      output req_mask,
      input  req_ready,
      input  busy
   );

   modport slave (
      input  req_valid,
      input  req_mask,
      output req_ready,
      output busy
   );
endinterface

// File: rtl/bank_inrd_sequencer.sv
// Walks the banks in ascending order, driving INRDENI and settling each enable,
// and gates synchronised IB pad data with the per-bank ready flag.
module bank_inrd_sequencer #(
   parameter int NUM_BANKS     = 6,
   parameter int SETTLE_CYCLES = 16,
   parameter int CNT_W         = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   bank_inrd_sequencer_if.slave ctl,
   output logic [NUM_BANKS-1:0] inrdeni,
   output logic [NUM_BANKS-1:0] bank_ready,
   input  logic [NUM_BANKS-1:0] pad_in,
   output logic [NUM_BANKS-1:0] pad_q
);

   localparam int IDX_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
   localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_BANKS - 1);
   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      APPLY,
      SETTLE
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     idx;
   logic [CNT_W-1:0]     cnt;
   logic [NUM_BANKS-1:0] target;
   logic [NUM_BANKS-1:0] sync1;
   logic [NUM_BANKS-1:0] sync2;
   logic                 rdy_q;
   logic                 busy_q;
   logic                 last;

   assign last          = (idx == LAST);
   assign ctl.req_ready = rdy_q;
   assign ctl.busy      = busy_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         cnt        <= '0;
         target     <= '0;
         inrdeni    <= '0;
         bank_ready <= '0;
         rdy_q      <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (ctl.req_valid) begin
                  target <= ctl.req_mask;
                  idx    <= '0;
                  state  <= SCAN;
                  rdy_q  <= 1'b0;
                  busy_q <= 1'b1;
               end
            end
            SCAN: begin
               if (target[idx] != inrdeni[idx]) begin
                  state <= APPLY;
               end else if (last) begin
                  state  <= IDLE;
                  rdy_q  <= 1'b1;
                  busy_q <= 1'b0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            APPLY: begin
               inrdeni[idx] <= target[idx];
               if (target[idx]) begin
                  cnt   <= CNT_INIT;
                  state <= SETTLE;
               end else begin
                  // ready drops with the enable so ready never outlives it
                  bank_ready[idx] <= 1'b0;
                  if (last) begin
                     state  <= IDLE;
                     rdy_q  <= 1'b1;
                     busy_q <= 1'b0;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SCAN;
                  end
               end
            end
            SETTLE: begin
               if (cnt == '0) begin
                  bank_ready[idx] <= 1'b1;
                  if (last) begin
                     state  <= IDLE;
                     rdy_q  <= 1'b1;
                     busy_q <= 1'b0;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SCAN;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state  <= IDLE;
               rdy_q  <= 1'b1;
               busy_q <= 1'b0;
            end
         endcase
      end
   end

   // two-flop synchroniser, then qualify with the registered ready flag
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         sync2 <= '0;
         pad_q <= '0;
      end else begin
         sync1 <= pad_in;
         sync2 <= sync1;
         pad_q <= sync2 & bank_ready;
      end
   end

endmodule

// File: tb/tb_bank_inrd_sequencer.sv
// Directed and randomised mask sequences checked against a per-bank
// timing schedule computed from scan/apply/settle costs.
module tb_bank_inrd_sequencer;

   localparam int NB = 6;
   localparam int S  = 4;

   logic          clk;
   logic          rst;
   logic [NB-1:0] inrdeni;
   logic [NB-1:0] bank_ready;
   logic [NB-1:0] pad_in;
   logic [NB-1:0] pad_q;

   bank_inrd_sequencer_if #(.NUM_BANKS(NB)) ifc ();

   bank_inrd_sequencer #(
      .NUM_BANKS    (NB),
      .SETTLE_CYCLES(S),
      .CNT_W        (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .ctl       (ifc.slave),
      .inrdeni   (inrdeni),
      .bank_ready(bank_ready),
      .pad_in    (pad_in),
      .pad_q     (pad_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [NB-1:0] exp_inr = '0;
   logic [NB-1:0] exp_br  = '0;
   logic [NB-1:0] exp_pad = '0;
   logic          exp_rdy = 1'b1;
   logic [NB-1:0] p1 = '0;
   logic [NB-1:0] p2 = '0;
   bit            pad_rand = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ":inrdeni"}, 32'(inrdeni), 32'(exp_inr));
      chk({tag, ":bank_ready"}, 32'(bank_ready), 32'(exp_br));
      chk({tag, ":pad_q"}, 32'(pad_q), 32'(exp_pad));
      chk({tag, ":req_ready"}, 32'(ifc.req_ready), 32'(exp_rdy));
      chk({tag, ":busy"}, 32'(ifc.busy), 32'(!exp_rdy));
      chk({tag, ":ready_wo_en"}, 32'(bank_ready & ~inrdeni), 32'd0);
   endtask

   // pad_q after edge k = pad_in at edge k-2 AND bank_ready before edge k
   task automatic step(input bit r);
      logic [NB-1:0] e;
      e  = p2 & exp_br;
      p2 = p1;
      p1 = pad_in;
      if (r) begin
         e  = '0;
         p1 = '0;
         p2 = '0;
      end
      @(posedge clk);
      #1;
      exp_pad = e;
      if (pad_rand) pad_in = NB'($urandom);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step(1'b0);
         chk_all("idle");
      end
   endtask

   task automatic do_reset();
      ifc.req_valid = 1'b0;
      rst = 1'b1;
      step(1'b1);
      exp_inr = '0;
      exp_br  = '0;
      exp_rdy = 1'b1;
      rst = 1'b0;
      chk_all("reset");
   endtask

   task automatic run_req(input logic [NB-1:0] mask, input bit junk,
                          input int abort_k);
      int t;
      int total;
      int s_inr[NB];
      int s_br[NB];
      logic [NB-1:0] br_val;
      ifc.req_valid = 1'b1;
      ifc.req_mask  = mask;
      step(1'b0);
      ifc.req_valid = 1'b0;
      exp_rdy = 1'b0;
      chk_all("accept");
      t = 1;
      br_val = mask;
      for (int i = 0; i < NB; i++) begin
         s_inr[i] = -1;
         s_br[i]  = -1;
         if (mask[i] != exp_inr[i]) begin
            s_inr[i] = t + 1;
            s_br[i]  = mask[i] ? t + 1 + S : t + 1;
            t += mask[i] ? 2 + S : 2;
         end else begin
            t += 1;
         end
      end
      total = t - 1;
      for (int k = 1; k <= total; k++) begin
         if (junk) begin
            ifc.req_valid = 1'($urandom);
            ifc.req_mask  = NB'($urandom);
         end
         if (k == abort_k) begin
            ifc.req_valid = 1'b0;
            do_reset();
            return;
         end
         step(1'b0);
         for (int i = 0; i < NB; i++) begin
            if (k == s_inr[i]) exp_inr[i] = mask[i];
            if (k == s_br[i]) exp_br[i] = br_val[i];
         end
         if (k == total) exp_rdy = 1'b1;
         chk_all("seq");
      end
      ifc.req_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      ifc.req_valid = 1'b0;
      ifc.req_mask  = '0;
      pad_in = '0;
      do_reset();
      do_reset();
      idle(2);

      run_req(6'b000001, 1'b0, -1);
      idle(1);

      pad_rand = 1'b0;
      pad_in = 6'b000001;
      for (int i = 0; i < 8; i++) begin
         pad_in[1] = ~pad_in[1];
         step(1'b0);
         chk_all("pad");
      end
      pad_rand = 1'b1;

      run_req(6'b000011, 1'b0, -1);
      run_req(6'b000010, 1'b0, -1);
      run_req(6'b000000, 1'b0, -1);
      run_req(6'b100001, 1'b0, -1);
      run_req(6'b100001, 1'b0, -1);
      run_req(6'b011010, 1'b1, -1);
      idle(2);

      run_req(6'b000000, 1'b0, -1);
      run_req(6'b000100, 1'b0, 6);
      idle(1);
      run_req(6'b000101, 1'b0, -1);

      for (int n = 0; n < 24; n++) begin
         run_req(NB'($urandom), 1'b1, -1);
         idle(int'($urandom_range(0, 2)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
